layer_trainer: RTL and testbench

LAYER_TRAINER -- requirements
Module: layer_trainer

---
 rtl/layer_trainer.sv | 201 ++++++++++++++++++++
 tb/tb_layer_trainer.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/layer_trainer.sv
// ---------------------------------------------------------------------------
// layer_trainer
//   Walks the rows of a neuron layer once per start request and produces the
//   gradient-descent update for each row:
//       w_new[c] = sat_dw (w[r][c] - ((delta[r] * x[c]) >>> lr_shift))
//       b_new    = sat_2dw(b[r]    - (delta[r]         >>> lr_shift))
//   Every row takes two cycles: CALC registers the new row, then WRITE strobes
//   train_en so the layer can store it.
//
// Ports
//   clk           : single clock, all state on the rising edge
//   rst_overall   : asynchronous active-low reset
//   start         : one-cycle request to run a pass (honoured only in IDLE)
//   values        : layer inputs x, column 0 in the MSBs
//   deltas        : per-row error (2*datawidth each), row 0 in the MSBs
//   weights_cur   : current weights, row 0 / column 0 in the MSBs
//   biases_cur    : current biases (2*datawidth each), row 0 in the MSBs
//   row_sel       : row currently being calculated / written
//   weight_update : new weights for row_sel, unused columns zero
//   bias_updates  : all new biases, row 0 in the MSBs, unused rows zero
//   train_en      : one-cycle write strobe per row
//   busy / done   : pass in progress / one-cycle completion pulse
// ---------------------------------------------------------------------------
module layer_trainer #(
    parameter int rows        = 4,
    parameter int columns     = 3,
    parameter int max_rows    = 4,
    parameter int max_columns = 3,
    parameter int datawidth   = 4,
    parameter int lr_shift    = 2,
    localparam int rsw        = (max_rows > 1) ? $clog2(max_rows) : 1
) (
    input  logic                               clk,
    input  logic                               rst_overall,
    input  logic                               start,
    input  logic [columns*datawidth-1:0]       values,
    input  logic [rows*2*datawidth-1:0]        deltas,
    input  logic [rows*columns*datawidth-1:0]  weights_cur,
    input  logic [rows*2*datawidth-1:0]        biases_cur,
    output logic [rsw-1:0]                     row_sel,
    output logic [max_columns*datawidth-1:0]   weight_update,
    output logic [max_rows*2*datawidth-1:0]    bias_updates,
    output logic                               train_en,
    output logic                               busy,
    output logic                               done
);

    localparam int dw = datawidth;
    localparam int pw = 3 * datawidth;

    typedef enum logic [1:0] {IDLE, CALC, WRITE, FIN} state_t;

    state_t state, next_state;

    logic [rsw-1:0]                    row_cnt;
    logic [columns*dw-1:0]             values_q;
    logic [rows*2*dw-1:0]              deltas_q;
    logic [rows*columns*dw-1:0]        weights_q;
    logic [rows*2*dw-1:0]              biases_q;

    logic signed [dw-1:0]              x_arr [columns];
    logic signed [2*dw-1:0]            d_arr [rows];
    logic signed [2*dw-1:0]            b_arr [rows];
    logic signed [dw-1:0]              w_arr [rows][columns];

    logic signed [pw-1:0]              prod;
    logic signed [pw-1:0]              prod_sh;
    logic signed [pw:0]                w_diff;
    logic signed [2*dw-1:0]            b_sh;
    logic signed [2*dw:0]              b_diff;
    logic [max_columns*dw-1:0]         w_row_new;
    logic [2*dw-1:0]                   b_new;

    // Clamp a wide signed difference into the datawidth weight range.
    function automatic logic [dw-1:0] sat_dw(input logic signed [pw:0] v);
        logic signed [pw:0] hi;
        logic signed [pw:0] lo;
        hi = (pw+1)'((2 ** (dw - 1)) - 1);
        lo = -hi - 1;
        if (v > hi)      return hi[dw-1:0];
        else if (v < lo) return lo[dw-1:0];
        else             return v[dw-1:0];
    endfunction

    // Clamp a wide signed difference into the 2*datawidth bias range.
    function automatic logic [2*dw-1:0] sat_2dw(input logic signed [2*dw:0] v);
        logic signed [2*dw:0] hi;
        logic signed [2*dw:0] lo;
        hi = (2*dw+1)'((2 ** (2*dw - 1)) - 1);
        lo = -hi - 1;
        if (v > hi)      return hi[2*dw-1:0];
        else if (v < lo) return lo[2*dw-1:0];
        else             return v[2*dw-1:0];
    endfunction

    assign row_sel = row_cnt;

    // State register.
    always_ff @(posedge clk or negedge rst_overall) begin
        if (!rst_overall) state <= IDLE;
        else              state <= next_state;
    end

    // Next-state logic; start is only looked at in IDLE.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:  if (start) next_state = CALC;
            CALC:  next_state = WRITE;
            WRITE: next_state = (row_cnt == rsw'(rows - 1)) ? FIN : CALC;
            FIN:   next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Status outputs decode straight from the state so reset clears them
    // in the same cycle.
    always_comb begin
        busy     = 1'b0;
        done     = 1'b0;
        train_en = 1'b0;
        case (state)
            CALC:  busy = 1'b1;
            WRITE: begin
                busy     = 1'b1;
                train_en = 1'b1;
            end
            FIN:   done = 1'b1;
            default: ;
        endcase
    end

    // Split the latched flat buses into per-row / per-column signed fields.
    always_comb begin
        for (int c = 0; c < columns; c++)
            x_arr[c] = values_q[(columns-1-c)*dw +: dw];
        for (int r = 0; r < rows; r++) begin
            d_arr[r] = deltas_q[(rows-1-r)*2*dw +: 2*dw];
            b_arr[r] = biases_q[(rows-1-r)*2*dw +: 2*dw];
            for (int c = 0; c < columns; c++)
                w_arr[r][c] = weights_q[((rows-1-r)*columns + (columns-1-c))*dw +: dw];
        end
    end

    // Update arithmetic for the current row. The product is kept at full
    // 3*datawidth precision and shifted arithmetically, so the learning-rate
    // step rounds toward minus infinity.
    always_comb begin
        w_row_new = '0;
        prod      = '0;
        prod_sh   = '0;
        w_diff    = '0;
        for (int c = 0; c < columns; c++) begin
            prod    = pw'(d_arr[row_cnt]) * pw'(x_arr[c]);
            prod_sh = prod >>> lr_shift;
            w_diff  = (pw+1)'(w_arr[row_cnt][c]) - (pw+1)'(prod_sh);
            w_row_new[(max_columns-1-c)*dw +: dw] = sat_dw(w_diff);
        end
        b_sh   = d_arr[row_cnt] >>> lr_shift;
        b_diff = (2*dw+1)'(b_arr[row_cnt]) - (2*dw+1)'(b_sh);
        b_new  = sat_2dw(b_diff);
    end

    // Datapath: operand snapshot at start, row results in CALC, row advance
    // in WRITE. Results are left untouched between passes.
    always_ff @(posedge clk or negedge rst_overall) begin
        if (!rst_overall) begin
            row_cnt       <= '0;
            values_q      <= '0;
            deltas_q      <= '0;
            weights_q     <= '0;
            biases_q      <= '0;
            weight_update <= '0;
            bias_updates  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        row_cnt   <= '0;
                        values_q  <= values;
                        deltas_q  <= deltas;
                        weights_q <= weights_cur;
                        biases_q  <= biases_cur;
                    end
                end
                CALC: begin
                    weight_update <= w_row_new;
                    for (int r = 0; r < max_rows; r++)
                        if (rsw'(r) == row_cnt)
                            bias_updates[(max_rows-1-r)*2*dw +: 2*dw] <= b_new;
                end
                WRITE: begin
                    if (row_cnt != rsw'(rows - 1))
                        row_cnt <= row_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_layer_trainer.sv
// ---------------------------------------------------------------------------
// tb_layer_trainer
//   Directed bench for layer_trainer with default parameters (4 rows,
//   3 columns, datawidth 4, lr_shift 2). Expected values are hand-computed.
// ---------------------------------------------------------------------------
module tb_layer_trainer;

    logic        clk;
    logic        rst_overall;
    logic        start;
    logic [11:0] values;
    logic [31:0] deltas;
    logic [47:0] weights_cur;
    logic [31:0] biases_cur;
    logic [1:0]  row_sel;
    logic [11:0] weight_update;
    logic [31:0] bias_updates;
    logic        train_en;
    logic        busy;
    logic        done;

    int vectors;
    int miscompares;

    // Pass 1 expectations, rows 0..3:
    //   x=[7,-3,4]; row0 d=2  w=[2,-1,5] b=100  -> [-1,1,3]  b=100
    //   row1 d=-16 w=[2,0,0]  b=0               -> [7,-8,7]  b=4
    //   row2 d=-128 w=[0,0,0] b=-20             -> [7,-8,7]  b=12
    //   row3 d=-128 w=[-8,7,1] b=120            -> [7,-8,7]  b=127
    logic [11:0] exp_w [4] = '{12'hF13, 12'h787, 12'h787, 12'h787};
    logic [31:0] exp_b [4] = '{32'h64000000, 32'h64040000, 32'h64040C00, 32'h64040C7F};

    layer_trainer dut (
        .clk           (clk),
        .rst_overall   (rst_overall),
        .start         (start),
        .values        (values),
        .deltas        (deltas),
        .weights_cur   (weights_cur),
        .biases_cur    (biases_cur),
        .row_sel       (row_sel),
        .weight_update (weight_update),
        .bias_updates  (bias_updates),
        .train_en      (train_en),
        .busy          (busy),
        .done          (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [63:0] observed,
                                input logic [63:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic check_idle_zero(input string tag);
        check_output({tag, " row_sel"},       64'(row_sel),       64'h0);
        check_output({tag, " weight_update"}, 64'(weight_update), 64'h0);
        check_output({tag, " bias_updates"},  64'(bias_updates),  64'h0);
        check_output({tag, " train_en"},      64'(train_en),      64'h0);
        check_output({tag, " busy"},          64'(busy),          64'h0);
        check_output({tag, " done"},          64'(done),          64'h0);
    endtask

    task automatic apply_stimulus(input logic [11:0] v, input logic [31:0] d,
                                  input logic [47:0] w, input logic [31:0] b);
        values      = v;
        deltas      = d;
        weights_cur = w;
        biases_cur  = b;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_overall = 1'b0;
        start       = 1'b0;
        apply_stimulus(12'h0, 32'h0, 48'h0, 32'h0);

        // Reset state.
        #2;
        check_idle_zero("reset");
        repeat (2) @(posedge clk);
        #1 rst_overall = 1'b1;

        // Pass 1: start at cycle 0, scramble inputs at cycle 1, stray start
        // at cycle 3.
        @(posedge clk);
        #1;
        apply_stimulus(12'h7D4, 32'h02F08080, 48'h2F5200000871, 32'h6400EC78);
        start = 1'b1;
        @(negedge clk);
        check_output("c0 busy", 64'(busy), 64'h0);
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            #1;
            start = (k == 3);
            if (k == 1) apply_stimulus(12'h000, 32'h7F7F7F7F, 48'h0, 32'h0);
            @(negedge clk);
            check_output($sformatf("c%0d train_en", k), 64'(train_en),
                         64'((k % 2 == 0) && (k >= 2) && (k <= 8)));
            check_output($sformatf("c%0d busy", k), 64'(busy), 64'((k >= 1) && (k <= 8)));
            check_output($sformatf("c%0d done", k), 64'(done), 64'(k == 9));
            if ((k % 2 == 0) && (k >= 2) && (k <= 8)) begin
                check_output($sformatf("c%0d row_sel", k), 64'(row_sel), 64'(k / 2 - 1));
                check_output($sformatf("c%0d weight_update", k), 64'(weight_update),
                             64'(exp_w[k / 2 - 1]));
                check_output($sformatf("c%0d bias_updates", k), 64'(bias_updates),
                             64'(exp_b[k / 2 - 1]));
            end
        end
        start = 1'b0;

        // Results hold after the pass.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_output("hold row_sel",       64'(row_sel),       64'h3);
        check_output("hold weight_update", 64'(weight_update), 64'h787);
        check_output("hold bias_updates",  64'(bias_updates),  64'h64040C7F);
        check_output("hold done",          64'(done),          64'h0);

        // Pass 2: x=[-8,1,-1]; row0 d=5 w=[3,3,3] b=-128 -> [7,2,5] b=-128;
        // row1 d=-64 w=[-8,0,0] b=0 -> [-8,7,-8] b=16. Reset lands in cycle 5.
        @(posedge clk);
        #1;
        apply_stimulus(12'h81F, 32'h05C00000, 48'h333800000000, 32'h80000000);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst_overall = 1'b0;
        #1;
        check_idle_zero("midpass reset");
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check_output("in reset done", 64'(done), 64'h0);
        end
        @(posedge clk);
        #1 rst_overall = 1'b1;

        // Pass 3 after reset release must start again from row 0.
        @(posedge clk);
        #1 start = 1'b1;
        @(negedge clk);
        check_output("p3 c0 busy", 64'(busy), 64'h0);
        for (int k = 1; k <= 9; k++) begin
            @(posedge clk);
            #1 start = 1'b0;
            @(negedge clk);
            check_output($sformatf("p3 c%0d done", k), 64'(done), 64'(k == 9));
            if (k == 2) begin
                check_output("p3 row0 train_en",      64'(train_en),      64'h1);
                check_output("p3 row0 row_sel",       64'(row_sel),       64'h0);
                check_output("p3 row0 weight_update", 64'(weight_update), 64'h725);
                check_output("p3 row0 bias_updates",  64'(bias_updates),  64'h80000000);
            end
            if (k == 4) begin
                check_output("p3 row1 train_en",      64'(train_en),      64'h1);
                check_output("p3 row1 row_sel",       64'(row_sel),       64'h1);
                check_output("p3 row1 weight_update", 64'(weight_update), 64'h878);
                check_output("p3 row1 bias_updates",  64'(bias_updates),  64'h80100000);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
